seg7_capture: RTL and testbench
===============================

# seg7_capture

Seven-segment capture and decoder: samples the multiplexed segment/anode bus driving the display and recovers the displayed hex value. Each digit's pattern is debounced and decoded back to a nibble, and the four digits are assembled into a 16-bit frame. Sits beside the display driver as a loopback/self-test monitor; drives status logic and the bench scoreboard.

## Interface
- STABLE_CYCLES, 4, consecutive identical samples required to accept a digit pattern (legal range 1..255)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- seg  input  7  segment pattern {g,f,e,d,c,b,a}, active-high
- an  input  4  digit anodes, active-low; an[i]=0 selects digit i (value[4i+3:4i])
- digit_value  output  16  latest accepted nibble per digit (live, updated per digit)
- digit_err  output  4  latest accepted pattern per digit was not a legal hex code
- frame_value  output  16  assembled value, held between frames
- frame_err  output  4  digit_err snapshot taken with frame_value
- frame_valid  output  1  one-cycle pulse: frame_value/frame_err just updated

## Operation
- Input stage: {an,seg} registered every cycle into sample register S; no other logic sees raw inputs.
- Legal select: S.an has exactly one bit low. Illegal (all high, or two or more low): stable counter cleared to 0, no acceptance, nothing stored.
- Stability: S compared with previous S (P). Legal and S==P: counter increments, saturating at STABLE_CYCLES. Legal and S!=P: counter loads 1. Counter width 8 bits.
- Acceptance: single event when counter transitions to STABLE_CYCLES (including the load-to-1 case when STABLE_CYCLES=1). Holding the pattern longer does not re-accept; a new acceptance needs a pattern change or an intervening illegal sample.
- Decode on acceptance: 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9, 0x77→A, 0x7C→B, 0x39→C, 0x5E→D, 0x79→E, 0x71→F. Any other pattern (including blank 0x00): nibble 0, err bit 1.
- Store: selected digit's nibble and err bit written; seen[i] set. Re-acceptance of an already-seen digit before frame completes overwrites nibble/err (latest wins).
- Frame: when seen becomes 4'b1111, frame_value<=digit_value, frame_err<=digit_err, frame_valid pulses, seen cleared. An acceptance in the same cycle as frame emission is stored and sets its seen bit for the next frame.
- Reset (any time, mid-dwell or mid-frame): S, P, counter, seen, all outputs to 0; frame_value/frame_err cleared.

## Timing
- Input change settles before edge E0; S captures it at E0.
- Pattern held: acceptance decided from S at E(STABLE_CYCLES-1); digit_value/digit_err updated at E(STABLE_CYCLES). Latency input change→digit_value = STABLE_CYCLES+1 edges.
- frame_value/frame_err/frame_valid registered one edge after the edge storing the last missing digit; frame_valid high exactly one cycle.
- Back-to-back frames: minimum spacing = 4 acceptances; no frame lost if acceptances occur every cycle.
- Reset values: digit_value=0, digit_err=0, frame_value=0, frame_err=0, frame_valid=0. First sample after rst deasserts is taken at next edge.

## Test plan
- STABLE_CYCLES=4, drive an=1110/1101/1011/0111 with seg 0x4F,0x66,0x6D,0x7D each held 8 cycles -> frame_valid single pulse, frame_value=16'h6543, frame_err=0; digit_value[3:0] updates 5 edges after first change.
- Glitch: digit 0 pattern 0x06 for 3 cycles then 0x5B held -> digit0=2 only, never 1; held 20 cycles -> one acceptance.
- Illegal anodes: an=1100 and 1111 with any seg for 10 cycles -> no acceptance, outputs unchanged; resumes normally afterwards.
- Bad code: digit 2 seg=0x00, others legal F,E,D -> frame_value=16'hD0EF... i.e. digit2 nibble 0, frame_err=4'b0100.
- Overwrite: digit 1 accepted as 7 then 8 before digits 2,3 seen -> frame carries 8 for digit 1, one frame only.
- Reset mid-frame: three digits seen, assert rst one cycle -> all outputs 0, seen cleared; fourth digit alone produces no frame_valid.

Source files
------------

// File: rtl/seg7_capture.sv
// seg7_capture
//   Loopback monitor for a multiplexed seven-segment display. The block
//   samples the segment/anode bus, debounces each digit pattern, decodes it
//   back to a hex nibble and assembles the four digits into a 16-bit frame.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   seg[6:0]     segment pattern {g,f,e,d,c,b,a}, active-high
//   an[3:0]      digit anodes, active-low; an[i]=0 selects digit i
//   digit_value  latest accepted nibble per digit (live)
//   digit_err    latest accepted pattern per digit was not a hex code
//   frame_value  assembled value, held between frames
//   frame_err    digit_err snapshot taken with frame_value
//   frame_valid  one-cycle pulse when frame_value/frame_err update
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digit_value,
  output logic [3:0]  digit_err,
  output logic [15:0] frame_value,
  output logic [3:0]  frame_err,
  output logic        frame_valid
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  // Returns {err, nibble}; unknown patterns decode to nibble 0 with err set.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F: r = 5'h00;
      7'h06: r = 5'h01;
      7'h5B: r = 5'h02;
      7'h4F: r = 5'h03;
      7'h66: r = 5'h04;
      7'h6D: r = 5'h05;
      7'h7D: r = 5'h06;
      7'h07: r = 5'h07;
      7'h7F: r = 5'h08;
      7'h6F: r = 5'h09;
      7'h77: r = 5'h0A;
      7'h7C: r = 5'h0B;
      7'h39: r = 5'h0C;
      7'h5E: r = 5'h0D;
      7'h79: r = 5'h0E;
      7'h71: r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  // Exactly one anode low selects a digit; anything else is not a digit slot.
  function automatic logic sel_legal(input logic [3:0] a);
    return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
  endfunction

  function automatic logic [1:0] sel_idx(input logic [3:0] a);
    logic [1:0] r;
    case (a)
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  logic [3:0]  s_an_q, p_an_q;
  logic [6:0]  s_seg_q, p_seg_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  seen_q, seen_d;
  logic [15:0] dv_q, dv_d, fv_q, fv_d;
  logic [3:0]  de_q, de_d, fe_q, fe_d;
  logic        fvld_q;

  logic        legal, same, accept, emit;
  logic [4:0]  dec;
  logic [1:0]  idx;

  always_comb begin
    legal  = sel_legal(s_an_q);
    same   = ({s_an_q, s_seg_q} == {p_an_q, p_seg_q});
    dec    = decode(s_seg_q);
    idx    = sel_idx(s_an_q);

    cnt_d = cnt_q;
    if (!legal)
      cnt_d = 8'd0;
    else if (!same)
      cnt_d = 8'd1;
    else if (cnt_q != STABLE)
      cnt_d = 8'(cnt_q + 8'd1);

    // Accept only on the transition into STABLE. A pattern change that
    // reloads to 1 counts as a transition even if the counter already sat
    // at 1 (STABLE_CYCLES == 1).
    accept = legal && (cnt_d == STABLE) && (!same || (cnt_q != STABLE));

    dv_d = dv_q;
    de_d = de_q;
    if (accept) begin
      dv_d[{idx, 2'b00} +: 4] = dec[3:0];
      de_d[idx]               = dec[4];
    end

    // Frame goes out the cycle after the last digit lands; a coincident
    // acceptance is counted toward the following frame.
    emit   = (seen_q == 4'b1111);
    seen_d = emit ? 4'b0000 : seen_q;
    if (accept)
      seen_d[idx] = 1'b1;

    fv_d = emit ? dv_q : fv_q;
    fe_d = emit ? de_q : fe_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_an_q  <= '0;
      s_seg_q <= '0;
      p_an_q  <= '0;
      p_seg_q <= '0;
      cnt_q   <= '0;
      seen_q  <= '0;
      dv_q    <= '0;
      de_q    <= '0;
      fv_q    <= '0;
      fe_q    <= '0;
      fvld_q  <= 1'b0;
    end else begin
      s_an_q  <= an;
      s_seg_q <= seg;
      p_an_q  <= s_an_q;
      p_seg_q <= s_seg_q;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      dv_q    <= dv_d;
      de_q    <= de_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
      fvld_q  <= emit;
    end
  end

  assign digit_value = dv_q;
  assign digit_err   = de_q;
  assign frame_value = fv_q;
  assign frame_err   = fe_q;
  assign frame_valid = fvld_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Testbench for seg7_capture: directed scenarios plus randomized traffic,
// checked against a run-length/table reference model through scoreboards.
module tb_seg7_capture;
  localparam int SC = 4;

  localparam logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                      7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                      7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = 7'h00;
  logic [3:0]  an  = 4'hF;
  logic [15:0] digit_value;
  logic [3:0]  digit_err;
  logic [15:0] frame_value;
  logic [3:0]  frame_err;
  logic        frame_valid;

  seg7_capture #(.STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an),
    .digit_value(digit_value), .digit_err(digit_err),
    .frame_value(frame_value), .frame_err(frame_err),
    .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] dv; logic [3:0] de; bit chk; } dexp_t;
  typedef struct { logic [15:0] v; logic [3:0] e; } fexp_t;

  dexp_t dq[$];
  fexp_t fq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int frames_exp = 0;
  int frames_seen = 0;

  // Reference model state
  int          run = 0;
  logic [10:0] last = '0;
  bit          last_ok = 0;
  logic [15:0] m_dv = '0;
  logic [3:0]  m_de = '0;
  logic [3:0]  m_seen = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find_pat(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (PAT[i] == s) return i;
    return -1;
  endfunction

  function automatic int sel_of(input logic [3:0] a);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) begin
      m = 4'b0001 << i;
      if (a == ~m) return i;
    end
    return -1;
  endfunction

  task automatic model_accept(input int d, input logic [6:0] s);
    int p;
    p = find_pat(s);
    m_dv[d*4 +: 4] = (p < 0) ? 4'h0 : 4'(p);
    m_de[d]        = (p < 0);
    m_seen[d]      = 1'b1;
    if (m_seen == 4'hF) begin
      fexp_t f;
      f.v = m_dv;
      f.e = m_de;
      fq.push_back(f);
      frames_exp++;
      m_seen = '0;
    end
  endtask

  // One clock of stimulus; the model sees exactly what the DUT will sample.
  task automatic step(input logic r, input logic [3:0] a, input logic [6:0] s);
    dexp_t e;
    int d;
    @(negedge clk);
    rst = r;
    an  = a;
    seg = s;
    if (r) begin
      if (dq.size() > 0) dq[dq.size()-1].chk = 1'b0;
      run = 0; last_ok = 0; m_dv = '0; m_de = '0; m_seen = '0;
      fq.delete();
    end else begin
      d = sel_of(a);
      if (d < 0) begin
        run = 0;
        last_ok = 0;
      end else begin
        if (last_ok && ({a, s} == last)) begin
          if (run < 255) run++;
        end else begin
          run = 1;
        end
        last = {a, s};
        last_ok = 1;
        if (run == SC) model_accept(d, s);
      end
    end
    e.dv = m_dv;
    e.de = m_de;
    e.chk = 1'b1;
    dq.push_back(e);
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    repeat (n) step(1'b0, a, s);
  endtask

  // Monitor: digit outputs lag the model by one entry; frames popped on pulse.
  initial begin
    dexp_t d;
    fexp_t f;
    logic [15:0] held_v;
    logic [3:0]  held_e;
    logic        prev_fv;
    held_v = '0; held_e = '0; prev_fv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        held_v = '0;
        held_e = '0;
      end
      if (dq.size() >= 2) begin
        d = dq.pop_front();
        if (d.chk) begin
          chk("digit_value", 32'(digit_value), 32'(d.dv));
          chk("digit_err", 32'(digit_err), 32'(d.de));
        end
      end
      if (frame_valid === 1'b1) begin
        frames_seen++;
        chk("frame_valid_width", 32'(prev_fv), 32'd0);
        if (fq.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
        end else begin
          f = fq.pop_front();
          held_v = f.v;
          held_e = f.e;
        end
      end
      chk("frame_value", 32'(frame_value), 32'(held_v));
      chk("frame_err", 32'(frame_err), 32'(held_e));
      prev_fv = frame_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] a;
    logic [6:0] s;
    logic [3:0] m;
    int r;

    repeat (3) step(1'b1, 4'hF, 7'h00);

    // Four digits 3,4,5,6 -> 16'h6543
    hold(4'b1110, 7'h4F, 8);
    hold(4'b1101, 7'h66, 8);
    hold(4'b1011, 7'h6D, 8);
    hold(4'b0111, 7'h7D, 8);

    // Glitch shorter than the debounce window, then a long hold
    hold(4'b1110, 7'h06, 3);
    hold(4'b1110, 7'h5B, 20);

    // Illegal anode selects, then resume to complete the frame
    for (int i = 0; i < 10; i++) step(1'b0, 4'b1100, 7'($urandom));
    for (int i = 0; i < 10; i++) step(1'b0, 4'b1111, 7'($urandom));
    hold(4'b1101, 7'h3F, 6);
    hold(4'b1011, 7'h77, 6);
    hold(4'b0111, 7'h7C, 6);

    // Blank pattern on digit 2 -> 16'hD0EF, err 4'b0100
    hold(4'b1110, 7'h71, 6);
    hold(4'b1101, 7'h79, 6);
    hold(4'b1011, 7'h00, 6);
    hold(4'b0111, 7'h5E, 6);

    // Digit 1 overwritten 7 -> 8 before the frame completes
    hold(4'b1110, 7'h3F, 6);
    hold(4'b1101, 7'h07, 6);
    hold(4'b1101, 7'h7F, 6);
    hold(4'b1011, 7'h4F, 6);
    hold(4'b0111, 7'h06, 6);

    // Reset with three digits seen; the fourth alone must not complete a frame
    hold(4'b1110, 7'h6F, 6);
    hold(4'b1101, 7'h39, 6);
    hold(4'b1011, 7'h5E, 6);
    step(1'b1, 4'b1011, 7'h5E);
    hold(4'b0111, 7'h77, 8);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      if (r < 8) begin
        m = 4'b0001 << (r % 4);
        a = ~m;
      end else begin
        a = 4'($urandom);
      end
      s = ($urandom_range(0, 4) == 0) ? 7'($urandom) : PAT[$urandom_range(0, 15)];
      hold(a, s, $urandom_range(1, 7));
    end

    hold(4'b1111, 7'h00, 10);
    @(posedge clk);
    #2;
    chk("frames_pending", 32'(fq.size()), 32'd0);
    chk("frame_count", 32'(frames_seen), 32'(frames_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
